// File: rtl/alu4_reg.sv
// rtl/alu4_reg.sv - 4-bit registered ALU with carry/zero/negative/overflow flags
module alu4_reg (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] OP1,
  input  logic [3:0] OP2,
  input  logic [2:0] OPCODE,
  output logic [3:0] RESULT,
  output logic       CARRY,
  output logic       ZERO,
  output logic       NEG,
  output logic       OVF
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } opcode_t;

  logic [4:0] sum5;
  logic [4:0] diff5;
  logic [3:0] res_d;
  logic       carry_d;
  logic       ovf_d;

  // Fifth bit of the zero-extended difference is the unsigned borrow.
  assign sum5  = {1'b0, OP1} + {1'b0, OP2};
  assign diff5 = {1'b0, OP1} - {1'b0, OP2};

  always_comb begin
    res_d   = 4'b0000;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (opcode_t'(OPCODE))
      OP_ADD: begin
        res_d   = sum5[3:0];
        carry_d = sum5[4];
        ovf_d   = (OP1[3] == OP2[3]) && (sum5[3] != OP1[3]);
      end
      OP_SUB: begin
        res_d   = diff5[3:0];
        carry_d = diff5[4];
        ovf_d   = (OP1[3] != OP2[3]) && (diff5[3] != OP1[3]);
      end
      OP_AND: res_d = OP1 & OP2;
      OP_OR:  res_d = OP1 | OP2;
      OP_XOR: res_d = OP1 ^ OP2;
      OP_NOT: res_d = ~OP1;
      OP_SHL: begin
        res_d   = {OP1[2:0], 1'b0};
        carry_d = OP1[3];
      end
      OP_SHR: begin
        res_d   = {1'b0, OP1[3:1]};
        carry_d = OP1[0];
      end
      default: res_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      RESULT <= 4'b0000;
      CARRY  <= 1'b0;
      ZERO   <= 1'b0;
      NEG    <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      RESULT <= res_d;
      CARRY  <= carry_d;
      ZERO   <= (res_d == 4'b0000);
      NEG    <= res_d[3];
      OVF    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu4_reg.sv
// tb/tb_alu4_reg.sv - table-driven and randomized self-checking bench for alu4_reg
module tb_alu4_reg;

  logic       clk;
  logic       rstn;
  logic [3:0] OP1;
  logic [3:0] OP2;
  logic [2:0] OPCODE;
  logic [3:0] RESULT;
  logic       CARRY;
  logic       ZERO;
  logic       NEG;
  logic       OVF;

  int checks = 0;
  int errors = 0;

  alu4_reg dut (
    .clk    (clk),
    .rstn   (rstn),
    .OP1    (OP1),
    .OP2    (OP2),
    .OPCODE (OPCODE),
    .RESULT (RESULT),
    .CARRY  (CARRY),
    .ZERO   (ZERO),
    .NEG    (NEG),
    .OVF    (OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] r;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
  } vec_t;

  vec_t vecs[17];

  // Reference computed from plain integer arithmetic on the operation rules.
  function automatic logic [7:0] model(input logic rst_n, input int a, input int b, input int op);
    int r, c, v, s, sa, sb, sv;
    r = 0; c = 0; v = 0;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    case (op)
      0: begin s = a + b; r = s % 16; c = (s > 15); sv = sa + sb; v = (sv > 7 || sv < -8); end
      1: begin s = a - b; r = (s + 16) % 16; c = (a < b); sv = sa - sb; v = (sv > 7 || sv < -8); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 15 - a;
      6: begin r = (a * 2) % 16; c = (a >= 8); end
      default: begin r = a / 2; c = a % 2; end
    endcase
    if (!rst_n) return 8'h00;
    return {r[3:0], c[0], (r == 0), (r >= 8), v[0]};
  endfunction

  task automatic apply(input logic rn, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    rstn = rn; OP1 = a; OP2 = b; OPCODE = op;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {RESULT, CARRY, ZERO, NEG, OVF};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got R=%b C=%b Z=%b N=%b V=%b, expected R=%b C=%b Z=%b N=%b V=%b",
               name, act[7:4], act[3], act[2], act[1], act[0],
               exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    logic [3:0] ra, rb;
    logic [2:0] rop;
    logic       rrn;

    vecs[0]  = '{1'b0, 4'hf, 4'hf, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'h0, 4'h0, 3'd0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'b0100, 4'b1010, 3'd7, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'b0111, 4'b0001, 3'd0, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 4'b1111, 4'b0001, 3'd0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'b0010, 4'b0101, 3'd1, 4'b1101, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'b1000, 4'b0001, 3'd1, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 4'b1100, 4'b1010, 3'd2, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 4'b1100, 4'b1010, 3'd3, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 4'b1100, 4'b1010, 3'd4, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'b1100, 4'b1010, 3'd5, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 4'b1100, 4'b1010, 3'd6, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 4'b1100, 4'b1010, 3'd7, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 4'b0101, 4'b0101, 3'd1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 4'b0111, 4'b1001, 3'd1, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 4'b1111, 4'b1111, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 4'b1111, 4'b1111, 3'd0, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b0};

    rstn = 1'b0; OP1 = 4'h0; OP2 = 4'h0; OPCODE = 3'd0;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].rstn, vecs[i].a, vecs[i].b, vecs[i].op);
      check($sformatf("vec%0d", i), {vecs[i].r, vecs[i].c, vecs[i].z, vecs[i].n, vecs[i].v});
    end

    // Reset dropped between back-to-back ops, then released on the next op.
    apply(1'b1, 4'd3, 4'd4, 3'd0);
    check("seq_add", 8'b0111_0000);
    apply(1'b1, 4'd9, 4'd2, 3'd1);
    check("seq_sub", 8'b0111_0001);
    apply(1'b0, 4'd9, 4'd9, 3'd0);
    check("seq_rst", 8'h00);
    apply(1'b1, 4'd9, 4'd9, 3'd0);
    check("seq_release", 8'b0010_1001);
    apply(1'b1, 4'd0, 4'd0, 3'd4);
    check("seq_zero", 8'b0000_0100);

    for (int i = 0; i < 400; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rop = 3'($urandom_range(0, 7));
      rrn = ($urandom_range(0, 15) != 0);
      apply(rrn, ra, rb, rop);
      check($sformatf("rand%0d op=%0d a=%0d b=%0d rstn=%0b", i, rop, ra, rb, rrn),
            model(rrn, int'(ra), int'(rb), int'(rop)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
